// File: rtl/mem_access_ctrl.sv
// Load/store unit bus front end: aligns requests, drives a held bus request, returns load words or store completions.
// Latency: accept at N, bus request at N+1, completion pulse one cycle after the ack; req_ready only while idle.
package mem_access_pkg;
    typedef enum logic [2:0] {
        MT_B  = 3'd0,
        MT_H  = 3'd1,
        MT_W  = 3'd2,
        MT_BU = 3'd3,
        MT_HU = 3'd4
    } mem_type;
endpackage

module mem_access_ctrl
    import mem_access_pkg::*;
#(
    parameter int DATA_LENGTH = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [31:0]            req_addr_i,
    input  logic                   req_we_i,
    input  mem_type                req_type_i,
    input  logic [DATA_LENGTH-1:0] req_wdata_i,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [31:0]            mem_addr_o,
    output logic [DATA_LENGTH-1:0] mem_wdata_o,
    output logic [3:0]             mem_strb_o,
    input  logic                   mem_ack_i,
    input  logic [DATA_LENGTH-1:0] mem_rdata_i,
    output logic                   ld_valid_o,
    output logic [DATA_LENGTH-1:0] ld_data_o,
    output mem_type                ld_type_o,
    output logic                   st_done_o,
    output logic                   misalign_o,
    output logic                   bus_err_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT);

    state_t                   state_q, state_d;
    logic [8:0]               cnt_q, cnt_d;
    logic                     tmo_q, tmo_d;
    logic [31:0]              addr_q;
    logic                     we_q;
    mem_type                  type_q;
    logic [DATA_LENGTH-1:0]   wdata_q;
    logic [3:0]               strb_q;
    logic [DATA_LENGTH-1:0]   ld_data_q;

    logic                     req_mis;
    logic [3:0]               req_strb;
    logic [DATA_LENGTH-1:0]   req_wdata;
    logic [1:0]               req_off;
    logic [8:0]               cnt_inc;
    logic                     accept;

    assign req_off = req_addr_i[1:0];
    assign accept  = (state_q == S_IDLE) && req_valid_i;
    assign cnt_inc = cnt_q + 9'd1;

    // Unknown type encodings are treated as misaligned so they never reach the bus.
    always_comb begin
        req_mis   = 1'b0;
        req_strb  = 4'b0000;
        req_wdata = req_wdata_i;
        case (req_type_i)
            MT_B, MT_BU: begin
                req_strb  = 4'b0001 << req_off;
                req_wdata = {4{req_wdata_i[7:0]}};
            end
            MT_H, MT_HU: begin
                req_mis   = req_off[0];
                req_strb  = 4'b0011 << req_off;
                req_wdata = {2{req_wdata_i[15:0]}};
            end
            MT_W: begin
                req_mis   = (req_off != 2'b00);
                req_strb  = 4'b1111;
            end
            default: req_mis = 1'b1;
        endcase
        if (!req_we_i) begin
            req_strb = 4'b0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 9'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // An ack in the same cycle the counter would reach the limit still completes normally.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    state_d = req_mis ? S_ERR : S_ACCESS;
                    cnt_d   = 9'd0;
                    tmo_d   = 1'b0;
                end
            end
            S_ACCESS: begin
                if (mem_ack_i) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TMO_LIMIT) begin
                        state_d = S_ERR;
                        tmo_d   = 1'b1;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q    <= 32'd0;
            we_q      <= 1'b0;
            type_q    <= MT_B;
            wdata_q   <= '0;
            strb_q    <= 4'b0000;
            ld_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                we_q    <= req_we_i;
                type_q  <= req_type_i;
                wdata_q <= req_wdata;
                strb_q  <= req_strb;
            end
            if ((state_q == S_ACCESS) && mem_ack_i) begin
                ld_data_q <= mem_rdata_i >> {addr_q[1:0], 3'b000};
            end
        end
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        mem_req_o   = (state_q == S_ACCESS);
        mem_we_o    = (state_q == S_ACCESS) && we_q;
        mem_strb_o  = (state_q == S_ACCESS) ? strb_q : 4'b0000;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = wdata_q;
        ld_valid_o  = (state_q == S_RESP) && !we_q;
        st_done_o   = (state_q == S_RESP) && we_q;
        misalign_o  = (state_q == S_ERR) && !tmo_q;
        bus_err_o   = (state_q == S_ERR) && tmo_q;
        ld_data_o   = ld_data_q;
        ld_type_o   = type_q;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter DATA_LENGTH, default 32, datapath width; only 32 is supported.
REQ-002 Parameter TIMEOUT, default 255, number of ACCESS cycles without mem_ack before a bus error is raised.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  execute stage presents a memory request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_type  input  mem_type  access size and sign (B, H, W, BU, HU).
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 mem_req  output  1  bus request, held until acknowledged.
REQ-012 mem_we  output  1  bus write enable.
REQ-013 mem_addr  output  32  word-aligned bus address, {req_addr[31:2], 2'b00}.
REQ-014 mem_wdata  output  32  lane-replicated store data.
REQ-015 mem_strb  output  4  byte write strobes.
REQ-016 mem_ack  input  1  bus completion; mem_rdata valid in the same cycle.
REQ-017 mem_rdata  input  32  bus read word.
REQ-018 ld_valid  output  1  one-cycle pulse: ld_data/ld_type valid for the sign/zero-extension stage.
REQ-019 ld_data  output  32  read word shifted right by 8*addr[1:0], not extended.
REQ-020 ld_type  output  mem_type  req_type of the completed load.
REQ-021 st_done  output  1  one-cycle pulse on store completion.
REQ-022 misalign  output  1  one-cycle pulse on a misaligned request.
REQ-023 bus_err  output  1  one-cycle pulse on a bus timeout.

Function
REQ-024 The FSM SHALL have exactly four states: IDLE, ACCESS, RESP, ERR.
REQ-025 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and all request fields are registered at acceptance.
REQ-026 A request SHALL be misaligned when H/HU has addr[0]=1 or W has addr[1:0]!=0; it goes IDLE->ERR, never asserts mem_req, and ERR pulses misalign for one cycle before returning to IDLE.
REQ-027 An aligned request SHALL go IDLE->ACCESS; mem_req=1 from the next cycle and is held with stable mem_addr, mem_we, mem_wdata and mem_strb until mem_ack is sampled.
REQ-028 Store strobes SHALL be B/BU: 4'b0001<<addr[1:0]; H/HU: 4'b0011<<addr[1:0]; W: 4'b1111. For loads mem_strb SHALL be 0.
REQ-029 Store data SHALL be B/BU: {4{wdata[7:0]}}; H/HU: {2{wdata[15:0]}}; W: wdata.
REQ-030 On mem_ack in ACCESS, the FSM SHALL go to RESP and register ld_data = mem_rdata >> (8*addr[1:0]); mem_req drops in the cycle after the ack.
REQ-031 In RESP, the block SHALL pulse ld_valid (loads) or st_done (stores) for exactly one cycle, then return to IDLE.
REQ-032 Minimum aligned latency SHALL be: acceptance at cycle N, mem_req at N+1, ack at N+1, and ld_valid/st_done at N+2.
REQ-033 A 9-bit timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-034 When the counter reaches TIMEOUT, the block SHALL pulse bus_err, drop mem_req, and return to IDLE without ld_valid or st_done.
REQ-035 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win: normal completion and no bus_err.
REQ-036 mem_ack received outside ACCESS SHALL be ignored.
REQ-037 misalign, bus_err, ld_valid and st_done SHALL be mutually exclusive in every cycle.

Reset
REQ-038 rst=1 at a clock edge SHALL force IDLE with a cleared counter, and every output 0 except req_ready=1.
REQ-039 Reset during ACCESS SHALL drop mem_req at that edge and discard the transaction, producing no completion pulse.

Verification
REQ-040 Load byte: LB addr 0x1003, ack next cycle with rdata 0xA1B2C3D4 -> mem_addr 0x1000, strb 0, ld_data 0x000000A1, ld_type B, ld_valid pulse at N+2.
REQ-041 Store half: SH addr 0x2002, wdata 0x0000BEEF -> mem_wdata 0xBEEFBEEF, strb 4'b1100, st_done one cycle after ack.
REQ-042 Misaligned: LW addr 0x3001 -> mem_req never asserts, misalign pulse at N+1, req_ready=1 at N+2.
REQ-043 Timeout: TIMEOUT=4, no ack -> mem_req high for 4 cycles, then bus_err pulse and return to IDLE; the ack-on-final-cycle variant completes normally with no bus_err.
REQ-044 Reset mid-access: assert rst during ACCESS, then ack one cycle later -> mem_req=0 after the edge and no ld_valid.
REQ-045 Back-to-back: two loads with req_valid held -> second accepted the cycle after the first ld_valid; bus ordering preserved.
